// File: rtl/piso_tx.sv
// piso_tx: parallel-in/serial-out transmitter, one bit per clk.
// Accepts a WIDTH-bit word over a valid/ready handshake and streams
// it out on sout, flagging the final bit of each word with sout_last.
// Back-to-back words stream with no gap between them.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-high
//   din        in   parallel word, captured only on accept
//   din_valid  in   upstream has a word on din
//   din_ready  out  word can be accepted this cycle (combinational)
//   sout       out  serial data bit (registered)
//   sout_valid out  sout carries a valid bit (registered)
//   sout_last  out  sout is the last bit of its word (registered)
//   busy       out  a word is being shifted, equals sout_valid

module piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_PREV = CW'(WIDTH - 2);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sout_q, sout_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;

    logic             at_last;
    logic             accept;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] shifted;

    // The bit currently on sout always sits at the transmit end of
    // shreg_q; the register shifts toward that end on every advance.
    assign first_bit = MSB_FIRST ? din[WIDTH-1] : din[0];
    assign next_bit  = MSB_FIRST ? shreg_q[WIDTH-2] : shreg_q[1];
    assign shifted   = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                 : {1'b0, shreg_q[WIDTH-1:1]};

    assign at_last   = (state_q == SHIFT) && (cnt_q == CNT_LAST);

    // Ready on the last bit lets the next word follow with no bubble.
    assign din_ready = !rst && ((state_q == IDLE) || at_last);
    assign accept    = din_valid && din_ready;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        sout_d  = sout_q;
        valid_d = valid_q;
        last_d  = last_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    shreg_d = din;
                    cnt_d   = '0;
                    sout_d  = first_bit;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                end
            end
            SHIFT: begin
                if (!at_last) begin
                    cnt_d   = cnt_q + 1'b1;
                    shreg_d = shifted;
                    sout_d  = next_bit;
                    last_d  = (cnt_q == CNT_PREV);
                end else if (accept) begin
                    shreg_d = din;
                    cnt_d   = '0;
                    sout_d  = first_bit;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                    shreg_d = '0;
                    cnt_d   = '0;
                    sout_d  = 1'b0;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                shreg_d = '0;
                cnt_d   = '0;
                sout_d  = 1'b0;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            sout_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            sout_q  <= sout_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign sout       = sout_q;
    assign sout_valid = valid_q;
    assign sout_last  = last_q;
    assign busy       = valid_q;

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed bench for piso_tx with MSB-first and LSB-first
// instances driven from the same word stream.

module tb_piso_tx;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;

    logic rdy_m, so_m, sv_m, sl_m, bz_m;
    logic rdy_l, so_l, sv_l, sl_l, bz_l;

    int passed;
    int total;

    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (rdy_m),
        .sout       (so_m),
        .sout_valid (sv_m),
        .sout_last  (sl_m),
        .busy       (bz_m)
    );

    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (rdy_l),
        .sout       (so_l),
        .sout_valid (sv_l),
        .sout_last  (sl_l),
        .busy       (bz_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle: nothing valid, outputs low, ready as given.
    task automatic idle_chk(input string tag, input logic exp_rdy);
        chk({tag, " sv_m"}, sv_m, 1'b0);
        chk({tag, " sv_l"}, sv_l, 1'b0);
        chk({tag, " so_m"}, so_m, 1'b0);
        chk({tag, " so_l"}, so_l, 1'b0);
        chk({tag, " sl_m"}, sl_m, 1'b0);
        chk({tag, " bz_m"}, bz_m, 1'b0);
        chk({tag, " rdy_m"}, rdy_m, exp_rdy);
        chk({tag, " rdy_l"}, rdy_l, exp_rdy);
    endtask

    // One shifting cycle: expected bits for both orders, last flag.
    task automatic cyc(input string tag, input logic bm,
                       input logic bl, input logic lst);
        chk({tag, " so_m"}, so_m, bm);
        chk({tag, " so_l"}, so_l, bl);
        chk({tag, " sv_m"}, sv_m, 1'b1);
        chk({tag, " sv_l"}, sv_l, 1'b1);
        chk({tag, " sl_m"}, sl_m, lst);
        chk({tag, " sl_l"}, sl_l, lst);
        chk({tag, " bz_m"}, bz_m, 1'b1);
        chk({tag, " rdy_m"}, rdy_m, lst);
        chk({tag, " rdy_l"}, rdy_l, lst);
        tick();
    endtask

    // Full word; sm/sl are the expected streams read left to right.
    task automatic word(input string tag, input logic [7:0] sm,
                        input logic [7:0] sl);
        logic [7:0] m;
        logic [7:0] l;
        m = sm;
        l = sl;
        for (int i = 0; i < 8; i++)
            cyc($sformatf("%s b%0d", tag, i), m[7-i], l[7-i], i == 7);
    endtask

    initial begin
        logic [7:0] m;
        logic [7:0] l;
        passed    = 0;
        total     = 0;
        rst       = 1'b1;
        din       = 8'hFF;
        din_valid = 1'b1;

        // Reset held two edges with valid high: reset wins.
        tick();
        tick();
        idle_chk("rst", 1'b0);
        rst       = 1'b0;
        din_valid = 1'b0;
        tick();
        idle_chk("post_rst0", 1'b1);
        tick();
        idle_chk("post_rst1", 1'b1);

        // Single word A5 (palindromic bit pattern in both orders).
        din       = 8'hA5;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        din       = 8'h00;
        word("a5", 8'hA5, 8'hA5);
        idle_chk("a5_end", 1'b1);
        tick();
        idle_chk("a5_idle", 1'b1);

        // Bit order: 1E -> MSB 00011110, LSB 01111000.
        din       = 8'h1E;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        din       = 8'hFF;
        word("1e", 8'h1E, 8'h78);
        idle_chk("1e_end", 1'b1);

        // Back-to-back F0 then 0F, valid held high.
        din       = 8'hF0;
        din_valid = 1'b1;
        tick();
        din = 8'h0F;
        word("f0", 8'hF0, 8'h0F);
        din_valid = 1'b0;
        din       = 8'h00;
        word("0f", 8'h0F, 8'hF0);
        idle_chk("b2b_end", 1'b1);

        // Backpressure: 3C offered at cnt=3 of A5, taken at cnt=7.
        din       = 8'hA5;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        m = 8'hA5;
        l = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                din       = 8'h3C;
                din_valid = 1'b1;
            end
            cyc($sformatf("bp b%0d", i), m[7-i], l[7-i], i == 7);
        end
        din_valid = 1'b0;
        din       = 8'h00;
        word("3c", 8'h3C, 8'h3C);
        idle_chk("bp_end", 1'b1);

        // Reset at cnt=4 of A5 aborts the word.
        din       = 8'hA5;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int i = 0; i < 4; i++)
            cyc($sformatf("ab b%0d", i), m[7-i], l[7-i], 1'b0);
        chk("ab cnt4 so_m", so_m, 1'b0);
        chk("ab cnt4 sv_m", sv_m, 1'b1);
        rst = 1'b1;
        #1;
        chk("ab rdy_in_rst", rdy_m, 1'b0);
        tick();
        idle_chk("ab_rst", 1'b0);
        rst = 1'b0;
        tick();
        idle_chk("ab_rel0", 1'b1);
        tick();
        idle_chk("ab_rel1", 1'b1);

        // Clean word after abort.
        din       = 8'h81;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        word("81", 8'h81, 8'h81);
        idle_chk("81_end", 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
